pol2cart_cordic: RTL and testbench
==================================

POL2CART_CORDIC -- requirements
Module: pol2cart_cordic

Interface
REQ-001 SHALL have parameter WIDTH, default 31, giving data ports [WIDTH:0] (32-bit signed at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  one-cycle strobe; radius/angle valid when high.
REQ-005 radius  input  WIDTH+1  signed magnitude, integer units.
REQ-006 angle  input  9  signed integer degrees.
REQ-007 out_valid  output  1  one-cycle strobe; x_out/y_out valid when high.
REQ-008 x_out  output  WIDTH+1  signed radius*cos(angle), integer.
REQ-009 y_out  output  WIDTH+1  signed radius*sin(angle), integer.

Function
REQ-010 SHALL implement CORDIC rotation mode, iterative, one micro-rotation per cycle, 16 iterations (i=0..15).
REQ-011 SHALL use FSM IDLE -> PRE (1 cycle) -> ITER (16 cycles) -> DONE (1 cycle) -> IDLE.
REQ-012 IDLE: in_valid=1 captures radius/angle at that edge, moves to PRE; in_valid=0 stays IDLE.
REQ-013 in_valid while not IDLE SHALL be ignored; in-flight operation unaffected.
REQ-014 Latency: capture edge E0; out_valid high for exactly the cycle after edge E0+18; next capture possible at edge E0+19.
REQ-015 Angle wrap at capture: angle>180 -> angle-360; angle<-180 -> angle+360; result in -180..180.
REQ-016 Internal angle z: signed Q9.16 degrees (26 bits); atan table entry i = round(atan(2^-i)*180/pi*65536), i=0 is 2949120.
REQ-017 PRE quadrant fold: z>90 -> x0=0, y0=r', z-=90; z<-90 -> x0=0, y0=-r', z+=90; else x0=r', y0=0.
REQ-018 r' = radius sign-extended to WIDTH+3 bits, left-shifted 2 guard bits (gain-comp handled per REQ-031).
REQ-019 Each ITER step: d=+1 if z>=0 else -1; x-=d*(y>>>i); y+=d*(x>>>i); z-=d*atan[i]; arithmetic shifts, two's complement, no saturation.
REQ-020 DONE: x_out/y_out = internal x/y rounded half-up after removing guard bits, truncated to WIDTH+1 bits.
REQ-021 x_out, y_out SHALL be 0 whenever out_valid=0.
REQ-022 Accuracy: |x_out-ideal|, |y_out-ideal| <= max(4, |radius|*2^-13) for |radius| <= 2^30.
REQ-023 radius=0 SHALL produce x_out=y_out=0 with normal latency; negative radius produces negated result.
REQ-024 Back-to-back in_valid on the IDLE cycle after DONE SHALL be accepted (no dead cycle beyond DONE).

Reset
REQ-025 rst_n low SHALL asynchronously force FSM to IDLE, iteration counter to 0, out_valid=0, x_out=0, y_out=0.
REQ-026 Reset mid-operation SHALL abort; no out_valid for the aborted transaction after release.
REQ-027 First capture allowed on first rising edge with rst_n high.
REQ-028 Internal x/y/z registers SHALL reset to 0 (no X propagation into outputs).

Configuration
REQ-029 Macro POL2CART_GAIN_COMP_EN selects gain compensation.
REQ-030 Defined: r' additionally multiplied by K=39797/65536 (~0.607253) in PRE, 48-bit intermediate, arithmetic shift right 16; outputs unscaled (REQ-022 applies).
REQ-031 Undefined: no multiplier; outputs carry CORDIC gain ~1.646760 (x_out ~ 1.64676*radius*cos); latency unchanged.

Verification
REQ-032 radius=1000, angle=0 -> 18 cycles later out_valid 1 cycle, x_out=1000+-4, y_out=0+-4; then outputs 0.
REQ-033 radius=1000000, angle=-135 -> x_out=-707107+-123, y_out=-707107+-123; angle=180 -> x_out=-1000000+-123, y_out=0+-123.
REQ-034 radius=500, angle=300 (wraps to -60) -> x_out=250+-4, y_out=-433+-4.
REQ-035 in_valid pulses at E0 and E0+5 -> only one out_valid at E0+18 reflecting E0 inputs; new pulse at E0+19 accepted.
REQ-036 rst_n low at E0+8 of a transaction -> out_valid, x_out, y_out 0 immediately; no out_valid after release.
REQ-037 POL2CART_GAIN_COMP_EN undefined, radius=1000, angle=0 -> x_out=1647+-4, y_out=0+-4.

Source files
------------

// File: rtl/pol2cart_cordic.sv
// Iterative CORDIC polar-to-cartesian converter: one micro-rotation per cycle, 16 iterations.
// Optional gain compensation is enabled by defining POL2CART_GAIN_COMP_EN.
module pol2cart_cordic #(
  parameter int WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic signed [WIDTH:0] radius,
  input  logic signed [8:0]     angle,
  output logic                  out_valid,
  output logic signed [WIDTH:0] x_out,
  output logic signed [WIDTH:0] y_out
);

  localparam int unsigned RW = WIDTH + 3;
  localparam int unsigned XW = WIDTH + 5;
  localparam int unsigned ZW = 26;
  localparam logic signed [ZW-1:0] Z_90 = 26'sd5898240;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

  state_t                  r_state;
  logic [3:0]              r_iter;
  logic signed [WIDTH:0]   r_radius;
  logic signed [XW-1:0]    r_x;
  logic signed [XW-1:0]    r_y;
  logic signed [ZW-1:0]    r_z;

  logic signed [9:0]       w_ang_wrap;
  logic signed [ZW-1:0]    w_z_cap;
  logic signed [RW-1:0]    w_r_ext;
  logic signed [XW-1:0]    w_rp;
  logic signed [XW-1:0]    w_x_sh;
  logic signed [XW-1:0]    w_y_sh;
  logic signed [XW-1:0]    w_x_rnd;
  logic signed [XW-1:0]    w_y_rnd;
  logic signed [ZW-1:0]    w_atan;

  // atan(2^-i) in Q9.16 degrees
  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 26'sd2949120;
      4'd1:    atan_lut = 26'sd1740967;
      4'd2:    atan_lut = 26'sd919879;
      4'd3:    atan_lut = 26'sd466945;
      4'd4:    atan_lut = 26'sd234379;
      4'd5:    atan_lut = 26'sd117304;
      4'd6:    atan_lut = 26'sd58666;
      4'd7:    atan_lut = 26'sd29335;
      4'd8:    atan_lut = 26'sd14668;
      4'd9:    atan_lut = 26'sd7334;
      4'd10:   atan_lut = 26'sd3667;
      4'd11:   atan_lut = 26'sd1833;
      4'd12:   atan_lut = 26'sd917;
      4'd13:   atan_lut = 26'sd458;
      4'd14:   atan_lut = 26'sd229;
      default: atan_lut = 26'sd115;
    endcase
  endfunction

  // Wrap the captured angle into -180..180
  always_comb begin
    w_ang_wrap = {angle[8], angle};
    if (w_ang_wrap > 10'sd180) begin
      w_ang_wrap = w_ang_wrap - 10'sd360;
    end else if (w_ang_wrap < -10'sd180) begin
      w_ang_wrap = w_ang_wrap + 10'sd360;
    end
  end

  assign w_z_cap = {w_ang_wrap, 16'd0};
  assign w_r_ext = {r_radius, 2'b00};

`ifdef POL2CART_GAIN_COMP_EN
  // Multiply before the guard shift so full-scale radius fits the 48-bit product
  logic signed [47:0] w_prod;
  assign w_prod = 48'(r_radius) * 48'sd39797;
  assign w_rp   = XW'(w_prod >>> 14);
`else
  assign w_rp   = XW'(w_r_ext);
`endif

  assign w_x_sh  = r_x >>> r_iter;
  assign w_y_sh  = r_y >>> r_iter;
  assign w_atan  = atan_lut(r_iter);
  assign w_x_rnd = (r_x + XW'(2)) >>> 2;
  assign w_y_rnd = (r_y + XW'(2)) >>> 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_iter    <= '0;
      r_radius  <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_radius <= radius;
            r_z      <= w_z_cap;
            r_iter   <= '0;
            r_state  <= S_PRE;
          end
        end
        // Fold into -90..90 so the iterations converge
        S_PRE: begin
          if (r_z > Z_90) begin
            r_x <= '0;
            r_y <= w_rp;
            r_z <= r_z - Z_90;
          end else if (r_z < -Z_90) begin
            r_x <= '0;
            r_y <= -w_rp;
            r_z <= r_z + Z_90;
          end else begin
            r_x <= w_rp;
            r_y <= '0;
          end
          r_state <= S_ITER;
        end
        S_ITER: begin
          if (!r_z[ZW-1]) begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan;
          end else begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan;
          end
          r_iter <= r_iter + 4'd1;
          if (r_iter == 4'd15) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          out_valid <= 1'b1;
          x_out     <= (WIDTH+1)'(w_x_rnd);
          y_out     <= (WIDTH+1)'(w_y_rnd);
          r_iter    <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pol2cart_cordic.sv
// Scoreboard bench for pol2cart_cordic: trig reference model, decoupled output monitor.
module tb_pol2cart_cordic;

  localparam int  W  = 31;
  localparam real PI = 3.14159265358979;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [W:0]    radius;
  logic signed [8:0]    angle;
  logic                 out_valid;
  logic signed [W:0]    x_out;
  logic signed [W:0]    y_out;

  pol2cart_cordic #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .radius    (radius),
    .angle     (angle),
    .out_valid (out_valid),
    .x_out     (x_out),
    .y_out     (y_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    real x;
    real y;
    real tol;
    int  cyc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_checks = 0;
  int   busy_until = 0;
  real  gain;

  task automatic chk_int(input string nm, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, req);
  endtask

  task automatic chk_near(input string nm, input real act, input real req, input real tol);
    n_checks++;
    if ((act - req <= tol) && (req - act <= tol)) n_pass++;
    else $display("FAIL %s: got %0.1f, want %0.2f +- %0.2f", nm, act, req, tol);
  endtask

  // Drive one in_valid pulse; queue an expectation only if the block should be idle
  task automatic send(input int r, input int a, input real tol_ovr);
    exp_t e;
    real  rad;
    real  t;
    radius   = r;
    angle    = 9'(a);
    in_valid = 1'b1;
    if (cyc + 1 >= busy_until) begin
      rad = real'(angle) * PI / 180.0;
      e.x = gain * real'(r) * $cos(rad);
      e.y = gain * real'(r) * $sin(rad);
      t   = real'((r < 0) ? -r : r) / 8192.0 + 1.0;
      if (t < 4.0) t = 4.0;
      e.tol = (tol_ovr > 0.0) ? tol_ovr : t * gain;
      e.cyc = cyc + 19;
      q.push_back(e);
      busy_until = cyc + 20;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc + 1 < busy_until) @(negedge clk);
  endtask

  function automatic int rand_radius();
    int mag;
    case ($urandom_range(0, 3))
      0:       mag = 0;
      1:       mag = int'($urandom_range(0, 1000));
      2:       mag = int'($urandom_range(0, 1 << 20));
      default: mag = int'($urandom_range(0, 1 << 30));
    endcase
    return ($urandom_range(0, 1) == 1) ? -mag : mag;
  endfunction

  function automatic int rand_angle();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  // Monitor: pop and compare on every out_valid; outputs must be zero otherwise
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, want no result pending", cyc);
        end else begin
          e = q.pop_front();
          chk_int("out_cycle", cyc, e.cyc);
          chk_near("x_out", real'(x_out), e.x, e.tol);
          chk_near("y_out", real'(y_out), e.y, e.tol);
        end
      end else begin
        chk_int("idle_x_out", x_out, 0);
        chk_int("idle_y_out", y_out, 0);
        if (q.size() > 0 && cyc >= q[0].cyc) begin
          e = q.pop_front();
          n_checks++;
          $display("FAIL missing_out_valid: got out_valid=0 at cycle %0d, want 1 at cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    real p;
    int  r0;
    int  a0;
    gain = 1.0;
    p    = 1.0;
    for (int i = 0; i < 16; i++) begin
      gain = gain * $sqrt(1.0 + p);
      p    = p / 4.0;
    end
`ifdef POL2CART_GAIN_COMP_EN
    gain = gain * 39797.0 / 65536.0;
`endif

    rst_n    = 1'b0;
    in_valid = 1'b0;
    radius   = '0;
    angle    = '0;
    repeat (3) @(negedge clk);
    chk_int("rst_out_valid", out_valid, 0);
    chk_int("rst_x_out", x_out, 0);
    chk_int("rst_y_out", y_out, 0);

    // Capture on the very first edge after release
    rst_n = 1'b1;
    send(1000, 0, 4.0);

    wait_idle(); send(1000000, -135, 0.0);
    wait_idle(); send(1000000, 180, 0.0);
    // 300/-300 do not fit the 9-bit port; 240/-240 take the same wrap paths
    wait_idle(); send(500, 240, 0.0);
    wait_idle(); send(500, -240, 0.0);
    wait_idle(); send(0, 77, 0.0);
    wait_idle(); send(-1000, 30, 0.0);
    wait_idle(); send(1000, 181, 0.0);
    wait_idle(); send(1000, -181, 0.0);
    wait_idle(); send(1000, 90, 0.0);
    wait_idle(); send(1000, -90, 0.0);
    wait_idle(); send(1000, 91, 0.0);
    wait_idle(); send(1000, 255, 0.0);
    wait_idle(); send(1 << 30, 45, 0.0);
    wait_idle(); send(-(1 << 30), -256, 0.0);

    // Pulse during operation is ignored; next pulse right after DONE is taken
    wait_idle(); send(777, 60, 0.0);
    repeat (3) @(negedge clk);
    send(999, -10, 0.0);
    wait_idle(); send(888, -45, 0.0);

    for (int t = 0; t < 40; t++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rand_radius(), rand_angle(), 0.0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 15)) @(negedge clk);
        send(rand_radius(), rand_angle(), 0.0);
      end
    end

    // Reset mid-operation aborts the transaction
    wait_idle(); send(123456, 37, 0.0);
    repeat (7) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_int("abort_out_valid", out_valid, 0);
    chk_int("abort_x_out", x_out, 0);
    chk_int("abort_y_out", y_out, 0);
    q.delete();
    busy_until = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    // Reset while the result is presented clears outputs asynchronously
    r0 = 54321;
    a0 = -100;
    send(r0, a0, 0.0);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk_int("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_int("async_out_valid", out_valid, 0);
    chk_int("async_x_out", x_out, 0);
    chk_int("async_y_out", y_out, 0);
    q.delete();
    busy_until = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(2000, 10, 0.0);

    for (int k = 0; k < 60 && q.size() > 0; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk_int("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
